// File: rtl/uart_imem_loader.sv
// uart_imem_loader
// Receives 8N1 bytes on rx, packs them little-endian into 32-bit words and
// writes each word to the instruction memory write port at successive word
// addresses. The core is held via busy while a load is running; a load ends
// after TIMEOUT_BITS idle bit periods, flushing any partial word zero-padded.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   rx         serial input, idle high, asynchronous to clk
//   wr_en      one-cycle instruction memory write strobe
//   wr_addr    word address for the write
//   wr_data    assembled 32-bit word
//   busy       load in progress (core holds PC in reset)
//   done       load complete, sticky until the next load starts
//   frame_err  sticky: a stop bit was sampled low
//   overflow   sticky: write address wrapped past 2^ADDR_W-1
//   word_count words written in the current load
//   tx         echo output
//
// Optional feature: define LOADER_ECHO_EN to retransmit every valid received
// byte on tx. Without it tx is constant 1 and no transmitter exists.
module uart_imem_loader #(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int ADDR_W       = 8,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count,
  output logic              tx
);

  localparam int DIV         = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W       = $clog2(DIV + 1);
  localparam int TIMEOUT_CYC = TIMEOUT_BITS * DIV;
  localparam int IDLE_W      = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIV);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} rxState_e;

  rxState_e          rxState_q;
  logic              rxMeta_q, rxSync_q, rxPrev_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2:0]        bitIdx_q;
  logic [7:0]        shift_q;
  logic [1:0]        byteIdx_q;
  logic [31:0]       word_q;
  logic [IDLE_W-1:0] idleCnt_q;
  logic              flushPend_q;
  logic              wrEn_q, busy_q, done_q, frameErr_q, overflow_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [31:0]       wrData_q;
  logic [ADDR_W:0]   wordCount_q;

  // Two-flop synchroniser on rx, plus a delayed copy for falling-edge detection.
  // Everything resets high so no false start edge appears after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Receive FSM, word packing, write port and session control. A write is
  // presented for one cycle; the address/count advance on the following edge.
  // A timeout with a partial word issues one flush write and ends the load one
  // cycle later via flushPend_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxState_q   <= S_IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= '0;
      shift_q     <= '0;
      byteIdx_q   <= '0;
      word_q      <= '0;
      idleCnt_q   <= '0;
      flushPend_q <= 1'b0;
      wrEn_q      <= 1'b0;
      wrAddr_q    <= '0;
      wrData_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frameErr_q  <= 1'b0;
      overflow_q  <= 1'b0;
      wordCount_q <= '0;
    end else begin
      wrEn_q <= 1'b0;

      if (wrEn_q) begin
        wrAddr_q    <= wrAddr_q + ADDR_W'(1);
        wordCount_q <= wordCount_q + (ADDR_W + 1)'(1);
        if (&wrAddr_q) overflow_q <= 1'b1;
      end

      if (flushPend_q) begin
        flushPend_q <= 1'b0;
        busy_q      <= 1'b0;
        done_q      <= 1'b1;
      end

      if (rxState_q == S_IDLE && busy_q && !flushPend_q) begin
        if (idleCnt_q == IDLE_END) begin
          idleCnt_q <= '0;
          if (byteIdx_q != 2'd0) begin
            wrEn_q      <= 1'b1;
            wrData_q    <= word_q;
            word_q      <= '0;
            byteIdx_q   <= '0;
            flushPend_q <= 1'b1;
          end else begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end else begin
          idleCnt_q <= idleCnt_q + IDLE_W'(1);
        end
      end

      case (rxState_q)
        S_IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            cnt_q     <= CNT_HALF;
            rxState_q <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == CNT_ONE) begin
            if (!rxSync_q) begin
              rxState_q <= S_DATA;
              cnt_q     <= CNT_FULL;
              bitIdx_q  <= '0;
              idleCnt_q <= '0;
              // First confirmed start bit outside a load opens a new one.
              if (!busy_q) begin
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                wrAddr_q    <= '0;
                wordCount_q <= '0;
                byteIdx_q   <= '0;
                word_q      <= '0;
              end
            end else begin
              rxState_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_ONE) begin
            shift_q <= {rxSync_q, shift_q[7:1]};
            cnt_q   <= CNT_FULL;
            if (bitIdx_q == 3'd7) rxState_q <= S_STOP;
            else bitIdx_q <= bitIdx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_ONE) begin
            if (rxSync_q) begin
              rxState_q <= S_IDLE;
              byteIdx_q <= byteIdx_q + 2'd1;
              if (byteIdx_q == 2'd3) begin
                wrEn_q   <= 1'b1;
                wrData_q <= {shift_q, word_q[23:0]};
                word_q   <= '0;
              end else begin
                word_q[{byteIdx_q, 3'b000} +: 8] <= shift_q;
              end
            end else begin
              frameErr_q <= 1'b1;
              rxState_q  <= S_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_WAIT_HIGH: begin
          if (rxSync_q) rxState_q <= S_IDLE;
        end
        default: rxState_q <= S_IDLE;
      endcase
    end
  end

  assign wr_en      = wrEn_q;
  assign wr_addr    = wrAddr_q;
  assign wr_data    = wrData_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign frame_err  = frameErr_q;
  assign overflow   = overflow_q;
  assign word_count = wordCount_q;

`ifdef LOADER_ECHO_EN
  typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} txState_e;

  txState_e         txState_q;
  logic [CNT_W-1:0] txCnt_q;
  logic [2:0]       txBit_q;
  logic [7:0]       txShift_q, hold_q;
  logic             holdValid_q, tx_q;
  logic             rxByteDone, txFree;

  // A valid byte is complete on the edge where its stop bit samples high, so
  // the transmitter can drive its start bit in the very next cycle.
  assign rxByteDone = (rxState_q == S_STOP) && (cnt_q == CNT_ONE) && rxSync_q;
  assign txFree     = (txState_q == T_IDLE) || (txState_q == T_STOP && txCnt_q == CNT_ONE);

  // Echo transmitter with a one-byte holding register; a newer byte replaces
  // a held one that has not started yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txState_q   <= T_IDLE;
      txCnt_q     <= '0;
      txBit_q     <= '0;
      txShift_q   <= '0;
      hold_q      <= '0;
      holdValid_q <= 1'b0;
      tx_q        <= 1'b1;
    end else if (txFree && (holdValid_q || rxByteDone)) begin
      tx_q      <= 1'b0;
      txState_q <= T_START;
      txCnt_q   <= CNT_FULL;
      txShift_q <= holdValid_q ? hold_q : shift_q;
      if (holdValid_q) begin
        holdValid_q <= rxByteDone;
        if (rxByteDone) hold_q <= shift_q;
      end
    end else begin
      if (rxByteDone) begin
        hold_q      <= shift_q;
        holdValid_q <= 1'b1;
      end
      if (txState_q != T_IDLE) begin
        if (txCnt_q == CNT_ONE) begin
          txCnt_q <= CNT_FULL;
          case (txState_q)
            T_START: begin
              tx_q      <= txShift_q[0];
              txShift_q <= {1'b0, txShift_q[7:1]};
              txBit_q   <= '0;
              txState_q <= T_DATA;
            end
            T_DATA: begin
              if (txBit_q == 3'd7) begin
                tx_q      <= 1'b1;
                txState_q <= T_STOP;
              end else begin
                tx_q      <= txShift_q[0];
                txShift_q <= {1'b0, txShift_q[7:1]};
                txBit_q   <= txBit_q + 3'd1;
              end
            end
            default: txState_q <= T_IDLE;
          endcase
        end else begin
          txCnt_q <= txCnt_q - CNT_ONE;
        end
      end
    end
  end

  assign tx = tx_q;
`else
  assign tx = 1'b1;
`endif

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader: directed table of loads, hand-written
// corner sequences (glitch, overflow, reset mid-byte) and randomized loads
// checked against a byte-list packing model.
module tb_uart_imem_loader;

  localparam int CLK_HZ       = 1600;
  localparam int BAUD         = 100;
  localparam int ADDR_W       = 2;
  localparam int TIMEOUT_BITS = 4;
  localparam int DIV          = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int TIMEOUT_CYC  = TIMEOUT_BITS * DIV;
  localparam int NADDR        = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              rx  = 1'b1;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy, done, frame_err, overflow;
  logic [ADDR_W:0]   word_count;
  logic              tx;

  uart_imem_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .frame_err(frame_err),
    .overflow(overflow), .word_count(word_count), .tx(tx)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic [63:0] b;
    logic [7:0]  badMask;
    int          nWr;
    logic [31:0] d0;
    logic [31:0] d1;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          wrEnInReset = 0;
  logic [7:0]  stimByte [32];
  logic        stimBad  [32];
  int          stimN;
  logic [ADDR_W-1:0] wrAddrQ [$];
  logic [31:0] wrDataQ [$];
  int          expAddrQ [$];
  logic [31:0] expDataQ [$];
  logic        modelFe, modelOvf;
  vec_t        vecs [4];

  // Write-port monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (wr_en) begin
      wrAddrQ.push_back(wr_addr);
      wrDataQ.push_back(wr_data);
    end
    if (!rst && wr_en) wrEnInReset <= wrEnInReset + 1;
  end

`ifdef LOADER_ECHO_EN
  logic [7:0] echoQ [$];
  logic [7:0] expEchoQ [$];
  logic [7:0] eb;

  // Decodes the echoed 8N1 stream by sampling mid-bit.
  initial begin
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        eb[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      echoQ.push_back(eb);
    end
  end
`endif

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveBit(input logic v);
    rx = v;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic isBad);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(b[i]);
    driveBit(!isBad);
    rx = 1'b1;
  endtask

  // Sends stimByte[0..stimN-1]; a bad-stop frame is followed by a full bit of
  // idle so the line is seen high again before the next start bit.
  task automatic applyStimulus(input int gapMax);
    int gap;
    wrAddrQ.delete();
    wrDataQ.delete();
`ifdef LOADER_ECHO_EN
    echoQ.delete();
`endif
    for (int i = 0; i < stimN; i++) begin
      sendFrame(stimByte[i], stimBad[i]);
      gap = stimBad[i] ? DIV : int'($urandom_range(0, gapMax));
      repeat (gap) @(negedge clk);
    end
  endtask

  // Reference: keep the good bytes, group by four little-endian, zero-pad the
  // last group; word k lands at address k mod 2^ADDR_W.
  function automatic void modelBuild();
    logic [7:0]  vals [$];
    logic [31:0] w;
    expAddrQ.delete();
    expDataQ.delete();
    for (int i = 0; i < stimN; i++) begin
      if (stimBad[i]) modelFe = 1'b1;
      else vals.push_back(stimByte[i]);
    end
    for (int k = 0; 4 * k < vals.size(); k++) begin
      w = '0;
      for (int j = 0; j < 4; j++)
        if (4 * k + j < vals.size()) w = w | ({24'b0, vals[4 * k + j]} << (8 * j));
      expDataQ.push_back(w);
      expAddrQ.push_back(k % NADDR);
      if (k % NADDR == NADDR - 1) modelOvf = 1'b1;
    end
`ifdef LOADER_ECHO_EN
    expEchoQ = vals;
`endif
  endfunction

  task automatic waitDone(input string tag);
    int k = 0;
    while (!done && k < TIMEOUT_CYC + 4 * DIV) begin
      @(negedge clk);
      k++;
    end
    checkOutput({tag, " done reached"}, done, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic checkSession(input string tag);
    int n;
    checkOutput({tag, " write count"}, wrDataQ.size(), expDataQ.size());
    n = (wrDataQ.size() < expDataQ.size()) ? wrDataQ.size() : expDataQ.size();
    for (int k = 0; k < n; k++) begin
      checkOutput($sformatf("%s wr_addr[%0d]", tag, k), wrAddrQ[k], expAddrQ[k]);
      checkOutput($sformatf("%s wr_data[%0d]", tag, k), wrDataQ[k], expDataQ[k]);
    end
    checkOutput({tag, " word_count"}, word_count, expDataQ.size());
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " frame_err"}, frame_err, modelFe);
    checkOutput({tag, " overflow"}, overflow, modelOvf);
`ifdef LOADER_ECHO_EN
    repeat (30 * DIV) @(negedge clk);
    checkOutput({tag, " echo count"}, echoQ.size(), expEchoQ.size());
    for (int k = 0; k < echoQ.size() && k < expEchoQ.size(); k++)
      checkOutput($sformatf("%s echo[%0d]", tag, k), echoQ[k], expEchoQ[k]);
`else
    checkOutput({tag, " tx idle"}, tx, 1'b1);
`endif
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " wr_en"}, wr_en, 1'b0);
    checkOutput({tag, " wr_addr"}, wr_addr, 0);
    checkOutput({tag, " wr_data"}, wr_data, 0);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " done"}, done, 1'b0);
    checkOutput({tag, " frame_err"}, frame_err, 1'b0);
    checkOutput({tag, " overflow"}, overflow, 1'b0);
    checkOutput({tag, " word_count"}, word_count, 0);
    checkOutput({tag, " tx"}, tx, 1'b1);
  endtask

  initial begin
    vecs[0] = '{n: 4, b: 64'h0000_0000_0050_0513, badMask: 8'h00, nWr: 1, d0: 32'h0050_0513, d1: 32'h0};
    vecs[1] = '{n: 8, b: 64'h0807_0605_0403_0201, badMask: 8'h00, nWr: 2, d0: 32'h0403_0201, d1: 32'h0807_0605};
    vecs[2] = '{n: 6, b: 64'h0000_0605_0403_0201, badMask: 8'h00, nWr: 2, d0: 32'h0403_0201, d1: 32'h0000_0605};
    vecs[3] = '{n: 5, b: 64'h0000_0000_5005_13AA, badMask: 8'h01, nWr: 1, d0: 32'h0050_0513, d1: 32'h0};
    modelFe  = 1'b0;
    modelOvf = 1'b0;

    // Reset state, during and after reset.
    repeat (3) @(negedge clk);
    checkReset("in reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checkReset("after release");

    // Short low glitch shorter than half a bit must be ignored.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("glitch busy", busy, 1'b0);
    checkOutput("glitch frame_err", frame_err, 1'b0);
    checkOutput("glitch writes", wrDataQ.size(), 0);

    // Directed loads with constant expected words.
    for (int v = 0; v < 4; v++) begin
      stimN = vecs[v].n;
      for (int i = 0; i < stimN; i++) begin
        stimByte[i] = vecs[v].b[8 * i +: 8];
        stimBad[i]  = vecs[v].badMask[i];
      end
      applyStimulus(2);
      checkOutput($sformatf("vec%0d busy during load", v), busy, 1'b1);
      waitDone($sformatf("vec%0d", v));
      modelBuild();
      expDataQ.delete();
      expAddrQ.delete();
      expDataQ.push_back(vecs[v].d0);
      expAddrQ.push_back(0);
      if (vecs[v].nWr > 1) begin
        expDataQ.push_back(vecs[v].d1);
        expAddrQ.push_back(1);
      end
      checkSession($sformatf("vec%0d", v));
    end

    // Randomized loads against the packing model.
    for (int s = 0; s < 6; s++) begin
      stimN = int'($urandom_range(1, 9));
      for (int i = 0; i < stimN; i++) begin
        stimByte[i] = 8'($urandom);
        stimBad[i]  = ($urandom_range(0, 7) == 0);
      end
      applyStimulus(20);
      waitDone($sformatf("rand%0d", s));
      modelBuild();
      checkSession($sformatf("rand%0d", s));
    end

    // Five words with a 2-bit address: the fifth wraps to address 0.
    stimN = 20;
    for (int i = 0; i < stimN; i++) begin
      stimByte[i] = 8'($urandom);
      stimBad[i]  = 1'b0;
    end
    applyStimulus(4);
    waitDone("wrap");
    modelBuild();
    checkSession("wrap");
    checkOutput("wrap 5th addr", (wrAddrQ.size() > 4) ? wrAddrQ[4] : 2'bxx, 2'd0);
    checkOutput("wrap overflow", overflow, 1'b1);

    // Reset in the middle of a byte discards the partial word.
    stimN = 2;
    stimByte[0] = 8'h11; stimBad[0] = 1'b0;
    stimByte[1] = 8'h22; stimBad[1] = 1'b0;
    applyStimulus(2);
    driveBit(1'b0);
    driveBit(1'b1);
    driveBit(1'b0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkReset("mid-byte reset");
    rx = 1'b1;
    modelFe  = 1'b0;
    modelOvf = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    stimN = 4;
    stimByte[0] = 8'hDE; stimByte[1] = 8'hAD; stimByte[2] = 8'hBE; stimByte[3] = 8'hEF;
    for (int i = 0; i < 4; i++) stimBad[i] = 1'b0;
    applyStimulus(2);
    waitDone("post-reset");
    checkOutput("post-reset word", (wrDataQ.size() > 0) ? wrDataQ[0] : 32'hx, 32'hEFBE_ADDE);
    checkOutput("post-reset count", word_count, 1);

    checkOutput("wr_en during reset", wrEnInReset, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
